// File: rtl/img_frame_buffer_uart_if.sv
// img_frame_buffer_uart_if: receive stream, pixel read port and transmit stream of the frame buffer
interface img_frame_buffer_uart_if #(
   parameter int ADDR_W = 12,
   parameter int PIX_W = 8
);
   logic [7:0] rx_data;
   logic rx_valid;
   logic clear_in;
   logic frame_done;
   logic rx_overflow;
   logic [ADDR_W-1:0] rd_addr;
   logic [PIX_W-1:0] rd_data;
   logic send_start;
   logic [7:0] tx_data;
   logic tx_valid;
   logic tx_ready;
   logic tx_busy;
   modport slave(
      input rx_data, rx_valid, clear_in, rd_addr, send_start, tx_ready,
      output frame_done, rx_overflow, rd_data, tx_data, tx_valid, tx_busy
   );
   modport master(
      output rx_data, rx_valid, clear_in, rd_addr, send_start, tx_ready,
      input frame_done, rx_overflow, rd_data, tx_data, tx_valid, tx_busy
   );
endinterface

// File: rtl/img_frame_buffer_uart.sv
// img_frame_buffer_uart: assembles UART bytes into a BRAM frame, serves random pixel reads and streams the frame back out
module img_frame_buffer_uart #(
   parameter int IMG_WIDTH = 64,
   parameter int IMG_HEIGHT = 64,
   parameter int PIXEL_BYTES = 1
) (
   input logic clk,
   input logic rst_in,
   img_frame_buffer_uart_if.slave bus
);
   localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
   localparam int ADDR_W = $clog2(NPIX);
   localparam int PIX_W = 8 * PIXEL_BYTES;
   localparam int LW = PIXEL_BYTES > 1 ? $clog2(PIXEL_BYTES) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
   localparam logic [LW-1:0] LAST_LANE = LW'(PIXEL_BYTES - 1);

   typedef enum logic [1:0] {RECV, FULL, FETCH, SEND} state_t;

   state_t state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, tx_addr_q, tx_addr_d;
   logic [LW-1:0] lane_q, lane_d, tx_lane_q, tx_lane_d;
   logic [PIX_W-1:0] asm_q, asm_d, wr_word, tx_shift_q, tx_shift_d, rd_data_q;
   logic frame_done_q, frame_done_d, ovf_q, ovf_d;
   logic tx_valid_q, tx_valid_d, tx_busy_q, tx_busy_d;
   logic we;
   logic [PIX_W-1:0] mem [NPIX];

   // Port A: receive writes only; send reads happen in the state register block below
   always_ff @(posedge clk)
      if (we) mem[wr_addr_q] <= wr_word;

   always_comb begin
      state_d = state_q;
      wr_addr_d = wr_addr_q;
      lane_d = lane_q;
      asm_d = asm_q;
      tx_addr_d = tx_addr_q;
      tx_lane_d = tx_lane_q;
      tx_shift_d = tx_shift_q;
      frame_done_d = frame_done_q;
      ovf_d = ovf_q | (bus.rx_valid && state_q != RECV);
      tx_valid_d = tx_valid_q;
      tx_busy_d = tx_busy_q;
      we = 1'b0;
      for (int b = 0; b < PIXEL_BYTES; b++)
         wr_word[8*b +: 8] = lane_q == LW'(b) ? bus.rx_data : asm_q[8*b +: 8];
      if (bus.clear_in) begin
         state_d = RECV;
         wr_addr_d = '0;
         lane_d = '0;
         frame_done_d = 1'b0;
         ovf_d = 1'b0;
         tx_valid_d = 1'b0;
         tx_busy_d = 1'b0;
      end else begin
         case (state_q)
            RECV: if (bus.rx_valid) begin
               asm_d = wr_word;
               we = lane_q == LAST_LANE;
               lane_d = we ? '0 : lane_q + LW'(1);
               if (we) begin
                  wr_addr_d = wr_addr_q == LAST_ADDR ? '0 : wr_addr_q + ADDR_W'(1);
                  frame_done_d = wr_addr_q == LAST_ADDR;
                  state_d = wr_addr_q == LAST_ADDR ? FULL : RECV;
               end
            end
            FULL: if (bus.send_start) begin
               state_d = FETCH;
               tx_busy_d = 1'b1;
               tx_addr_d = '0;
               tx_lane_d = '0;
            end
            FETCH: begin
               state_d = SEND;
               tx_valid_d = 1'b1;
            end
            SEND: if (tx_valid_q && bus.tx_ready) begin
               if (tx_lane_q == LAST_LANE) begin
                  // one bubble per word while the next word is fetched
                  tx_valid_d = 1'b0;
                  tx_lane_d = '0;
                  tx_busy_d = tx_addr_q != LAST_ADDR;
                  state_d = tx_addr_q == LAST_ADDR ? FULL : FETCH;
                  tx_addr_d = tx_addr_q == LAST_ADDR ? tx_addr_q : tx_addr_q + ADDR_W'(1);
               end else begin
                  tx_lane_d = tx_lane_q + LW'(1);
                  tx_shift_d = tx_shift_q >> 8;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q <= RECV;
         wr_addr_q <= '0;
         lane_q <= '0;
         asm_q <= '0;
         tx_addr_q <= '0;
         tx_lane_q <= '0;
         tx_shift_q <= '0;
         frame_done_q <= 1'b0;
         ovf_q <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_busy_q <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q <= state_d;
         wr_addr_q <= wr_addr_d;
         lane_q <= lane_d;
         asm_q <= asm_d;
         tx_addr_q <= tx_addr_d;
         tx_lane_q <= tx_lane_d;
         tx_shift_q <= state_q == FETCH ? mem[tx_addr_q] : tx_shift_d;
         frame_done_q <= frame_done_d;
         ovf_q <= ovf_d;
         tx_valid_q <= tx_valid_d;
         tx_busy_q <= tx_busy_d;
         rd_data_q <= mem[bus.rd_addr];
      end
   end

   assign bus.frame_done = frame_done_q;
   assign bus.rx_overflow = ovf_q;
   assign bus.rd_data = rd_data_q;
   assign bus.tx_data = tx_shift_q[7:0];
   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_busy = tx_busy_q;
endmodule

// File: tb/tb_img_frame_buffer_uart.sv
// tb_img_frame_buffer_uart: directed bench for a 64x64x1 and a 4x4x2 frame buffer
module tb_img_frame_buffer_uart;
   logic clk = 1'b0;
   logic rst1, rst2;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   img_frame_buffer_uart_if #(.ADDR_W(12), .PIX_W(8)) i1();
   img_frame_buffer_uart_if #(.ADDR_W(4), .PIX_W(16)) i2();

   img_frame_buffer_uart #(.IMG_WIDTH(64), .IMG_HEIGHT(64), .PIXEL_BYTES(1)) d1 (.clk(clk), .rst_in(rst1), .bus(i1));
   img_frame_buffer_uart #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIXEL_BYTES(2)) d2 (.clk(clk), .rst_in(rst2), .bus(i2));

   function automatic logic [15:0] wval(input int w);
      return 16'h1234 + 16'(w) * 16'h4444;
   endfunction

   function automatic logic [7:0] ebyte(input int k);
      logic [15:0] v;
      v = wval(k / 2);
      return (k % 2) ? v[15:8] : v[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rx1(input logic [7:0] v);
      i1.rx_data = v;
      i1.rx_valid = 1'b1;
      tick();
      i1.rx_valid = 1'b0;
   endtask

   task automatic rx2(input logic [7:0] v);
      i2.rx_data = v;
      i2.rx_valid = 1'b1;
      tick();
      i2.rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      {i1.rx_data, i1.rx_valid, i1.clear_in, i1.rd_addr, i1.send_start, i1.tx_ready} = '0;
      {i2.rx_data, i2.rx_valid, i2.clear_in, i2.rd_addr, i2.send_start, i2.tx_ready} = '0;
      rst1 = 1'b1;
      rst2 = 1'b1;
      repeat (3) tick();
      checks++;
      if ({i1.frame_done, i1.rx_overflow, i1.tx_valid, i1.tx_busy} !== 4'b0) begin
         errors++; $display("FAIL reset_d1_flags: got %b want 0000", {i1.frame_done, i1.rx_overflow, i1.tx_valid, i1.tx_busy});
      end
      checks++;
      if ({i1.tx_data, i1.rd_data} !== 16'h0) begin
         errors++; $display("FAIL reset_d1_data: got %h want 0000", {i1.tx_data, i1.rd_data});
      end
      checks++;
      if ({i2.frame_done, i2.rx_overflow, i2.tx_valid, i2.tx_busy} !== 4'b0) begin
         errors++; $display("FAIL reset_d2_flags: got %b want 0000", {i2.frame_done, i2.rx_overflow, i2.tx_valid, i2.tx_busy});
      end
      checks++;
      if ({i2.tx_data, i2.rd_data} !== 24'h0) begin
         errors++; $display("FAIL reset_d2_data: got %h want 000000", {i2.tx_data, i2.rd_data});
      end
      rst1 = 1'b0;
      rst2 = 1'b0;
      tick();
   endtask

   task automatic test_frame_8bit();
      for (int i = 0; i < 4096; i++) begin
         rx1(8'(i));
         if (i == 4094) begin
            checks++;
            if (i1.frame_done !== 1'b0) begin
               errors++; $display("FAIL frame8_early_done: got %b want 0", i1.frame_done);
            end
         end
      end
      checks++;
      if (i1.frame_done !== 1'b1) begin
         errors++; $display("FAIL frame8_done: got %b want 1", i1.frame_done);
      end
      i1.rd_addr = 12'd300;
      tick();
      checks++;
      if (i1.rd_data !== 8'd44) begin
         errors++; $display("FAIL frame8_rd300: got %0d want 44", i1.rd_data);
      end
      i1.rd_addr = 12'd4095;
      tick();
      checks++;
      if (i1.rd_data !== 8'd255) begin
         errors++; $display("FAIL frame8_rd4095: got %0d want 255", i1.rd_data);
      end
      i1.rd_addr = 12'd1;
      tick();
      checks++;
      if (i1.rd_data !== 8'd1) begin
         errors++; $display("FAIL frame8_rd1: got %0d want 1", i1.rd_data);
      end
   endtask

   task automatic test_pix2();
      for (int k = 0; k < 32; k++) begin
         i2.send_start = (k == 31);
         rx2(ebyte(k));
         if (k == 15 || k == 30) begin
            checks++;
            if (i2.frame_done !== 1'b0) begin
               errors++; $display("FAIL pix2_early_done k=%0d: got %b want 0", k, i2.frame_done);
            end
         end
      end
      i2.send_start = 1'b0;
      checks++;
      if (i2.frame_done !== 1'b1) begin
         errors++; $display("FAIL pix2_done: got %b want 1", i2.frame_done);
      end
      tick();
      checks++;
      if ({i2.tx_busy, i2.tx_valid} !== 2'b00) begin
         errors++; $display("FAIL pix2_send_ignored: busy,valid got %b want 00", {i2.tx_busy, i2.tx_valid});
      end
      for (int w = 0; w < 16; w += 5) begin
         i2.rd_addr = 4'(w);
         tick();
         checks++;
         if (i2.rd_data !== wval(w)) begin
            errors++; $display("FAIL pix2_word%0d: got %h want %h", w, i2.rd_data, wval(w));
         end
      end
   endtask

   task automatic test_overflow();
      rx2(8'hAA);
      checks++;
      if ({i2.rx_overflow, i2.frame_done} !== 2'b11) begin
         errors++; $display("FAIL ovf_flags: ovf,done got %b want 11", {i2.rx_overflow, i2.frame_done});
      end
      i2.rd_addr = 4'd0;
      tick();
      checks++;
      if (i2.rd_data !== 16'h1234) begin
         errors++; $display("FAIL ovf_word0: got %h want 1234", i2.rd_data);
      end
   endtask

   task automatic test_send();
      for (int rep = 0; rep < 2; rep++) begin
         int idx, c;
         logic stalled;
         logic [7:0] last;
         i2.send_start = 1'b1;
         tick();
         i2.send_start = 1'b0;
         checks++;
         if ({i2.tx_busy, i2.tx_valid} !== 2'b10) begin
            errors++; $display("FAIL send%0d_fetch: busy,valid got %b want 10", rep, {i2.tx_busy, i2.tx_valid});
         end
         tick();
         checks++;
         if ({i2.tx_valid, i2.tx_data} !== {1'b1, 8'h34}) begin
            errors++; $display("FAIL send%0d_first: valid,data got %h want 134", rep, {i2.tx_valid, i2.tx_data});
         end
         idx = 0;
         c = 0;
         stalled = 1'b0;
         last = '0;
         while (idx < 32 && c < 500) begin
            if (stalled) begin
               checks++;
               if ({i2.tx_valid, i2.tx_data} !== {1'b1, last}) begin
                  errors++; $display("FAIL send%0d_stable: got %h want %h", rep, {i2.tx_valid, i2.tx_data}, {1'b1, last});
               end
            end
            i2.tx_ready = (c % 3 == 2);
            stalled = i2.tx_valid && !i2.tx_ready;
            last = i2.tx_data;
            if (i2.tx_valid && i2.tx_ready) begin
               checks++;
               if (i2.tx_data !== ebyte(idx)) begin
                  errors++; $display("FAIL send%0d_byte%0d: got %h want %h", rep, idx, i2.tx_data, ebyte(idx));
               end
               idx++;
            end
            tick();
            c++;
         end
         i2.tx_ready = 1'b0;
         checks++;
         if (idx !== 32) begin
            errors++; $display("FAIL send%0d_timeout: got %0d bytes want 32", rep, idx);
         end
         checks++;
         if ({i2.tx_busy, i2.tx_valid, i2.frame_done} !== 3'b001) begin
            errors++; $display("FAIL send%0d_end: busy,valid,done got %b want 001", rep, {i2.tx_busy, i2.tx_valid, i2.frame_done});
         end
      end
   endtask

   task automatic test_clear_abort();
      int hs, c;
      i2.send_start = 1'b1;
      tick();
      i2.send_start = 1'b0;
      i2.tx_ready = 1'b1;
      hs = 0;
      c = 0;
      while (hs < 5 && c < 100) begin
         if (i2.tx_valid) hs++;
         tick();
         c++;
      end
      checks++;
      if (hs !== 5) begin
         errors++; $display("FAIL abort_timeout: got %0d handshakes want 5", hs);
      end
      i2.clear_in = 1'b1;
      i2.rx_data = 8'h77;
      i2.rx_valid = 1'b1;
      tick();
      i2.clear_in = 1'b0;
      i2.rx_valid = 1'b0;
      i2.tx_ready = 1'b0;
      checks++;
      if ({i2.tx_valid, i2.tx_busy, i2.rx_overflow, i2.frame_done} !== 4'b0) begin
         errors++; $display("FAIL abort_flags: valid,busy,ovf,done got %b want 0000", {i2.tx_valid, i2.tx_busy, i2.rx_overflow, i2.frame_done});
      end
      i2.send_start = 1'b1;
      tick();
      i2.send_start = 1'b0;
      tick();
      checks++;
      if ({i2.tx_busy, i2.tx_valid} !== 2'b00) begin
         errors++; $display("FAIL abort_send_in_recv: busy,valid got %b want 00", {i2.tx_busy, i2.tx_valid});
      end
      rx2(8'h5A);
      rx2(8'h00);
      i2.rd_addr = 4'd0;
      tick();
      checks++;
      if (i2.rd_data !== 16'h005A) begin
         errors++; $display("FAIL abort_word0: got %h want 005a", i2.rd_data);
      end
   endtask

   task automatic test_reset_midframe();
      rx1(8'h11);
      checks++;
      if (i1.rx_overflow !== 1'b1) begin
         errors++; $display("FAIL rst_ovf_set: got %b want 1", i1.rx_overflow);
      end
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      checks++;
      if ({i1.rx_overflow, i1.frame_done} !== 2'b00) begin
         errors++; $display("FAIL rst_flags: ovf,done got %b want 00", {i1.rx_overflow, i1.frame_done});
      end
      for (int i = 0; i < 10; i++) rx1(8'hE0 + 8'(i));
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      checks++;
      if (i1.frame_done !== 1'b0) begin
         errors++; $display("FAIL rst_mid_done: got %b want 0", i1.frame_done);
      end
      for (int i = 0; i < 4096; i++) begin
         rx1(8'(i + 7));
         if (i == 4094) begin
            checks++;
            if (i1.frame_done !== 1'b0) begin
               errors++; $display("FAIL rst_refill_early: got %b want 0", i1.frame_done);
            end
         end
      end
      checks++;
      if (i1.frame_done !== 1'b1) begin
         errors++; $display("FAIL rst_refill_done: got %b want 1", i1.frame_done);
      end
      i1.rd_addr = 12'd0;
      tick();
      checks++;
      if (i1.rd_data !== 8'd7) begin
         errors++; $display("FAIL rst_refill_pix0: got %0d want 7", i1.rd_data);
      end
      i1.rd_addr = 12'd4095;
      tick();
      checks++;
      if (i1.rd_data !== 8'd6) begin
         errors++; $display("FAIL rst_refill_pix4095: got %0d want 6", i1.rd_data);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_frame_8bit();
      test_pix2();
      test_overflow();
      test_send();
      test_clear_abort();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
